// File: rtl/uart_rx_fifo_top_if.sv
// Receiver-to-consumer bundle: serial input, FWFT head word with its error
// flags, valid/ready handshake, overrun status/clear and FIFO level.
interface uart_rx_fifo_top_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                        rx;
  logic [DATA_BITS-1:0]        data_out;
  logic                        parity_err;
  logic                        frame_err;
  logic                        data_valid;
  logic                        data_ready;
  logic                        overrun;
  logic                        clr_overrun;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  modport master (
    output rx, data_ready, clr_overrun,
    input  data_out, parity_err, frame_err, data_valid, overrun, fifo_level
  );

  modport slave (
    input  rx, data_ready, clr_overrun,
    output data_out, parity_err, frame_err, data_valid, overrun, fifo_level
  );
endinterface

// File: rtl/uart_rx_fifo_top.sv
// UART receiver with oversampling tick generator, majority-vote framing FSM
// and a first-word-fall-through FIFO holding {parity_err, frame_err, data}.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a 1->0 transition between ticks
// ST_START  | inside start bit; voted 1 at mid-bit means false start
// ST_DATA   | shifting DATA_BITS bits in, LSB first
// ST_PARITY | checking the parity bit against the received data
// ST_STOP   | stop bit(s); push happens at mid-point of the last one
module uart_rx_fifo_top #(
  parameter int pBAUD_RATE    = 9600,
  parameter int pSYS_CLK_FREQ = 50000000,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int OVERSAMPLE    = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input logic               sys_clk,
  input logic               rst,
  uart_rx_fifo_top_if.slave bus
);
  localparam int DIV = pSYS_CLK_FREQ / (pBAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int BW  = $clog2(DATA_BITS) + 1;
  localparam int WW  = DATA_BITS + 2;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic                 r_rx_meta, r_rx_sync, r_prev_rx;
  logic [DW-1:0]        r_div_cnt;
  logic                 w_tick;
  state_t               r_state, w_state_nxt;
  logic [OW-1:0]        r_os_cnt, w_os_nxt;
  logic [BW-1:0]        r_bit_cnt, w_bit_nxt;
  logic                 r_s0, r_s1, w_s0_nxt, w_s1_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_perr, r_ferr, w_perr_nxt, w_ferr_nxt;
  logic                 w_vote, w_par_exp;
  logic                 w_push;
  logic [WW-1:0]        w_push_word;

  logic [WW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_overrun;
  logic                 w_empty, w_full, w_pop, w_wr, w_drop;
  logic [WW-1:0]        w_head;

  // Two-flop synchroniser for the asynchronous rx pin; idles high.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Free-running down-counter; tick fires on terminal count zero.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= DW'(DIV - 1);
    end else if (r_div_cnt == '0) begin
      r_div_cnt <= DW'(DIV - 1);
    end else begin
      r_div_cnt <= r_div_cnt - DW'(1);
    end
  end

  assign w_tick    = (r_div_cnt == '0);
  assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
  assign w_par_exp = (PARITY == 1) ? ^r_shift : ~^r_shift;

  // FSM and datapath registers; prev_rx tracks the line on every tick so a
  // held-low line never looks like a new falling edge.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_prev_rx <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_os_cnt  <= w_os_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_s0      <= w_s0_nxt;
      r_s1      <= w_s1_nxt;
      r_shift   <= w_shift_nxt;
      r_perr    <= w_perr_nxt;
      r_ferr    <= w_ferr_nxt;
      if (w_tick) r_prev_rx <= r_rx_sync;
    end
  end

  // Next-state logic: samples at MID-1/MID, votes at MID+1, bit ends at OVERSAMPLE-1.
  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_s0_nxt    = r_s0;
    w_s1_nxt    = r_s1;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_ferr_nxt  = r_ferr;
    w_push      = 1'b0;
    w_push_word = '0;
    if (w_tick) begin
      if (r_state == ST_IDLE) begin
        if (!r_rx_sync && r_prev_rx) begin
          // the detecting tick is sample 0 of the start bit
          w_state_nxt = ST_START;
          w_os_nxt    = OW'(1);
          w_bit_nxt   = '0;
          w_perr_nxt  = 1'b0;
          w_ferr_nxt  = 1'b0;
        end
      end else begin
        w_os_nxt = (r_os_cnt == OW'(OVERSAMPLE - 1)) ? '0 : r_os_cnt + OW'(1);
        if (r_os_cnt == OW'(MID - 1)) w_s0_nxt = r_rx_sync;
        if (r_os_cnt == OW'(MID))     w_s1_nxt = r_rx_sync;
        if (r_os_cnt == OW'(MID + 1)) begin
          case (r_state)
            ST_START:  if (w_vote) w_state_nxt = ST_IDLE;
            ST_DATA:   w_shift_nxt = {w_vote, r_shift[DATA_BITS-1:1]};
            ST_PARITY: if (w_vote != w_par_exp) w_perr_nxt = 1'b1;
            ST_STOP: begin
              if (!w_vote) w_ferr_nxt = 1'b1;
              if (r_bit_cnt == BW'(STOP_BITS - 1)) begin
                w_push      = 1'b1;
                w_push_word = {w_perr_nxt, w_ferr_nxt, r_shift};
                w_state_nxt = ST_IDLE;
              end
            end
            default: ;
          endcase
        end
        if (r_os_cnt == OW'(OVERSAMPLE - 1)) begin
          case (r_state)
            ST_START: begin
              w_state_nxt = ST_DATA;
              w_bit_nxt   = '0;
            end
            ST_DATA: begin
              if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
                w_state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
                w_bit_nxt   = '0;
              end else begin
                w_bit_nxt = r_bit_cnt + BW'(1);
              end
            end
            ST_PARITY: begin
              w_state_nxt = ST_STOP;
              w_bit_nxt   = '0;
            end
            ST_STOP: w_bit_nxt = r_bit_cnt + BW'(1);
            default: ;
          endcase
        end
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW + 1)'(FIFO_DEPTH));
  assign w_pop   = !w_empty && bus.data_ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // FIFO pointers, level and sticky overrun; a drop wins over a clear.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: ;
      endcase
      if (w_drop)               r_overrun <= 1'b1;
      else if (bus.clr_overrun) r_overrun <= 1'b0;
    end
  end

  // Storage needs no reset: outputs are gated by the empty flag.
  always_ff @(posedge sys_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_word;
  end

  assign w_head         = r_mem[r_rd_ptr];
  assign bus.data_valid = !w_empty;
  assign bus.data_out   = w_empty ? '0 : w_head[DATA_BITS-1:0];
  assign bus.frame_err  = w_empty ? 1'b0 : w_head[DATA_BITS];
  assign bus.parity_err = w_empty ? 1'b0 : w_head[DATA_BITS+1];
  assign bus.overrun    = r_overrun;
  assign bus.fifo_level = r_count;
endmodule

// File: tb/tb_uart_rx_fifo_top.sv
// Directed bench: three receiver configurations (8N1, 8E1, 8N2) at
// 160 clocks per bit; popped words are captured per instance in queues.
module tb_uart_rx_fifo_top;
  localparam int BIT = 160;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic seen;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  always #5 clk = ~clk;

  uart_rx_fifo_top_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus0 ();
  uart_rx_fifo_top_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus1 ();
  uart_rx_fifo_top_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus2 ();

  uart_rx_fifo_top #(.pBAUD_RATE(10000), .pSYS_CLK_FREQ(1600000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4))
    u0 (.sys_clk(clk), .rst(rst_n), .bus(bus0));
  uart_rx_fifo_top #(.pBAUD_RATE(10000), .pSYS_CLK_FREQ(1600000), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4))
    u1 (.sys_clk(clk), .rst(rst_n), .bus(bus1));
  uart_rx_fifo_top #(.pBAUD_RATE(10000), .pSYS_CLK_FREQ(1600000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16), .FIFO_DEPTH(4))
    u2 (.sys_clk(clk), .rst(rst_n), .bus(bus2));

  always @(negedge clk) begin
    if (bus0.data_valid && bus0.data_ready) q0.push_back({bus0.parity_err, bus0.frame_err, bus0.data_out});
    if (bus1.data_valid && bus1.data_ready) q1.push_back({bus1.parity_err, bus1.frame_err, bus1.data_out});
    if (bus2.data_valid && bus2.data_ready) q2.push_back({bus2.parity_err, bus2.frame_err, bus2.data_out});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_rx(input int line, input logic b);
    case (line)
      0:       bus0.rx = b;
      1:       bus1.rx = b;
      default: bus2.rx = b;
    endcase
  endtask

  // bits[0] is the start bit; the line is left idle high afterwards
  task automatic send_bits(input int line, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(line, bits[i]);
      wait_cyc(BIT);
    end
    set_rx(line, 1'b1);
  endtask

  task automatic expect_word(input int line, input logic [9:0] exp, input string tag);
    logic [9:0] w;
    w = 'x;
    case (line)
      0:       if (q0.size() > 0) w = q0.pop_front();
      1:       if (q1.size() > 0) w = q1.pop_front();
      default: if (q2.size() > 0) w = q2.pop_front();
    endcase
    chk(tag, {22'd0, w}, {22'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.rx = 1'b1; bus1.rx = 1'b1; bus2.rx = 1'b1;
    bus0.data_ready = 1'b1; bus1.data_ready = 1'b1; bus2.data_ready = 1'b1;
    bus0.clr_overrun = 1'b0; bus1.clr_overrun = 1'b0; bus2.clr_overrun = 1'b0;
    seen = 1'b0;
    wait_cyc(5);
    chk("rst_valid", bus0.data_valid, 0);
    chk("rst_level", bus0.fifo_level, 0);
    chk("rst_overrun", bus0.overrun, 0);
    chk("rst_data", {bus0.parity_err, bus0.frame_err, bus0.data_out}, 0);
    rst_n = 1'b1;
    wait_cyc(50);

    // 8N1 single word
    send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
    wait_cyc(100);
    expect_word(0, {2'b00, 8'hA5}, "t1_a5");
    chk("t1_single", q0.size(), 0);

    // even parity: correct, wrong, correct with odd popcount
    send_bits(1, {1'b1, 1'b0, 8'h03, 1'b0}, 11);
    send_bits(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
    send_bits(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    wait_cyc(100);
    expect_word(1, {2'b00, 8'h03}, "t2_par_ok");
    expect_word(1, {2'b10, 8'h03}, "t2_par_bad");
    expect_word(1, {2'b00, 8'h07}, "t2_par_ok_odd");
    chk("t2_parity_none_line", bus0.parity_err, 0);

    // two stop bits, second one low
    send_bits(2, {1'b0, 1'b1, 8'h5A, 1'b0}, 11);
    wait_cyc(300);
    send_bits(2, {1'b1, 1'b1, 8'h11, 1'b0}, 11);
    wait_cyc(100);
    expect_word(2, {2'b01, 8'h5A}, "t3_stop2_err");
    expect_word(2, {2'b00, 8'h11}, "t3_clean");

    // overflow and sticky overrun
    bus0.data_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_bits(0, {1'b1, 8'(k), 1'b0}, 10);
    wait_cyc(200);
    chk("t4_level_full", bus0.fifo_level, 4);
    chk("t4_overrun", bus0.overrun, 1);
    chk("t4_head", bus0.data_out, 8'h01);
    bus0.data_ready = 1'b1;
    wait_cyc(10);
    bus0.data_ready = 1'b0;
    for (int k = 1; k <= 4; k++) expect_word(0, {2'b00, 8'(k)}, "t4_order");
    chk("t4_drop5", q0.size(), 0);
    chk("t4_level_empty", bus0.fifo_level, 0);
    chk("t4_overrun_sticky", bus0.overrun, 1);
    bus0.clr_overrun = 1'b1;
    wait_cyc(1);
    bus0.clr_overrun = 1'b0;
    chk("t4_overrun_clr", bus0.overrun, 0);

    // push and pop in the same cycle with the FIFO full
    for (int k = 0; k < 4; k++) send_bits(0, {1'b1, 8'h21 + 8'(k), 1'b0}, 10);
    wait_cyc(200);
    chk("t5_level_full", bus0.fifo_level, 4);
    fork
      send_bits(0, {1'b1, 8'h06, 1'b0}, 10);
      begin : poll
        int n;
        n = 0;
        while (!seen && n < 2500) begin
          @(posedge clk); #1;
          if (u0.w_push === 1'b1) begin
            seen = 1'b1;
            bus0.data_ready = 1'b1;
          end
          n++;
        end
        @(posedge clk); #1;
        bus0.data_ready = 1'b0;
      end
    join
    wait_cyc(50);
    chk("t5_push_seen", seen, 1);
    chk("t5_level", bus0.fifo_level, 4);
    chk("t5_no_overrun", bus0.overrun, 0);
    expect_word(0, {2'b00, 8'h21}, "t5_popped");
    bus0.data_ready = 1'b1;
    wait_cyc(10);
    expect_word(0, {2'b00, 8'h22}, "t5_drain1");
    expect_word(0, {2'b00, 8'h23}, "t5_drain2");
    expect_word(0, {2'b00, 8'h24}, "t5_drain3");
    expect_word(0, {2'b00, 8'h06}, "t5_drain_06");

    // 40-cycle glitch is a false start
    bus0.rx = 1'b0;
    wait_cyc(40);
    bus0.rx = 1'b1;
    wait_cyc(2000);
    chk("t6_glitch_none", q0.size(), 0);
    chk("t6_glitch_level", bus0.fifo_level, 0);

    // break: one word, then silence while held low
    bus0.rx = 1'b0;
    wait_cyc(BIT * 12);
    expect_word(0, {2'b01, 8'h00}, "t6_break");
    wait_cyc(BIT * 8);
    bus0.rx = 1'b1;
    wait_cyc(400);
    chk("t6_break_once", q0.size(), 0);

    // reset mid-frame
    bus0.data_ready = 1'b0;
    send_bits(0, {1'b1, 8'h77, 1'b0}, 10);
    wait_cyc(200);
    chk("t6_pre_rst_level", bus0.fifo_level, 1);
    fork
      send_bits(0, {1'b1, 8'h55, 1'b0}, 10);
      begin
        wait_cyc(700);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", bus0.data_valid, 0);
        chk("t6_rst_level", bus0.fifo_level, 0);
        chk("t6_rst_data", {bus0.parity_err, bus0.frame_err, bus0.data_out}, 0);
      end
    join
    wait_cyc(20);
    rst_n = 1'b1;
    wait_cyc(200);
    chk("t6_post_rst_level", bus0.fifo_level, 0);
    q0.delete();
    bus0.data_ready = 1'b1;
    send_bits(0, {1'b1, 8'h3C, 1'b0}, 10);
    wait_cyc(100);
    expect_word(0, {2'b00, 8'h3C}, "t6_after_rst");
    chk("t6_after_rst_single", q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
